lin_frame_rx: RTL and testbench



---
 rtl/lin_frame_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_lin_frame_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lin_frame_rx.sv
// lin_frame_rx - LIN frame receiver.
// Listens on one bus line and decodes break, delimiter, sync, protected PID,
// NDATA data bytes and checksum. When a frame passes every check it presents
// the PID and data with a one-cycle frame_valid pulse.
// Ports:
//   sys_clk      system clock, rising edge
//   rst          asynchronous reset, active high
//   sdi          serial LIN line, idle high (recessive)
//   rx_pid       received identifier, parity bits stripped
//   rx_data      data bytes, byte k in [8k+7:8k], unused bytes zero
//   frame_valid  one-cycle pulse: frame received and checked
//   rx_busy      high from delimiter entry until frame end or abort
//   sync_err     one-cycle pulse: sync byte was not 8'h55
//   parity_err   one-cycle pulse: PID parity bits wrong
//   framing_err  one-cycle pulse: bad start/stop bit or inter-byte timeout
//   checksum_err one-cycle pulse: checksum mismatch
module lin_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned NDATA        = 8,
  parameter int unsigned ENHANCED_CS  = 1,
  parameter int unsigned TIMEOUT_BITS = 14
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        sdi,
  output logic [5:0]  rx_pid,
  output logic [63:0] rx_data,
  output logic        frame_valid,
  output logic        rx_busy,
  output logic        sync_err,
  output logic        parity_err,
  output logic        framing_err,
  output logic        checksum_err
);

  localparam logic [15:0] BRK_CYC   = 16'(13 * CLKS_PER_BIT);
  localparam logic [15:0] BIT_CYC   = 16'(CLKS_PER_BIT);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] TO_CYC    = 16'(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [3:0]  IDX_CS    = 4'(NDATA + 2);

  typedef enum logic [2:0] {IDLE, DELIM, START, DATA, STOP, GAP, DONE} state_t;

  state_t      state_q;
  logic [1:0]  sync_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [3:0]  idx_q;
  logic [7:0]  sh_q;
  logic [5:0]  pid_q;
  logic [63:0] buf_q;
  logic [7:0]  sum_q;

  logic        sdi_s;
  logic [15:0] cnt_sat_d;
  logic        pid_ok_d;
  logic [7:0]  sum_add_d;
  logic [8:0]  sum_raw_d;
  logic [2:0]  dsel_d;

  // Synchronizer resets to the recessive level so reset release never
  // looks like the start of a break.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], sdi};
  end

  always_comb begin
    sdi_s     = sync_q[1];
    cnt_sat_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    pid_ok_d  = (sh_q[6] == (sh_q[0] ^ sh_q[1] ^ sh_q[2] ^ sh_q[4])) &&
                (sh_q[7] == ~(sh_q[1] ^ sh_q[3] ^ sh_q[4] ^ sh_q[5]));
    // Carry out of bit 7 is folded back into bit 0.
    sum_raw_d = {1'b0, sum_q} + {1'b0, sh_q};
    sum_add_d = sum_raw_d[7:0] + {7'd0, sum_raw_d[8]};
    dsel_d    = 3'(idx_q - 4'd2);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      pid_q        <= '0;
      buf_q        <= '0;
      sum_q        <= '0;
      rx_pid       <= '0;
      rx_data      <= '0;
      frame_valid  <= 1'b0;
      rx_busy      <= 1'b0;
      sync_err     <= 1'b0;
      parity_err   <= 1'b0;
      framing_err  <= 1'b0;
      checksum_err <= 1'b0;
    end else begin
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
      parity_err   <= 1'b0;
      framing_err  <= 1'b0;
      checksum_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sdi_s) begin
            cnt_q <= cnt_sat_d;
          end else if (cnt_q >= BRK_CYC) begin
            // This first high cycle already counts toward the delimiter.
            state_q <= DELIM;
            cnt_q   <= 16'd1;
            rx_busy <= 1'b1;
            idx_q   <= '0;
            buf_q   <= '0;
            sum_q   <= '0;
          end else begin
            cnt_q <= '0;
          end
        end
        DELIM: begin
          if (!sdi_s) begin
            if (cnt_q >= BIT_CYC) begin
              state_q <= START;
              cnt_q   <= '0;
            end else begin
              state_q     <= IDLE;
              rx_busy     <= 1'b0;
              cnt_q       <= '0;
              framing_err <= 1'b1;
            end
          end else if (cnt_q > TO_CYC) begin
            state_q     <= IDLE;
            rx_busy     <= 1'b0;
            cnt_q       <= '0;
            framing_err <= 1'b1;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (sdi_s) begin
              state_q     <= IDLE;
              rx_busy     <= 1'b0;
              framing_err <= 1'b1;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            sh_q  <= {sdi_s, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_q + 4'd1;
            if (!sdi_s) begin
              state_q     <= IDLE;
              rx_busy     <= 1'b0;
              framing_err <= 1'b1;
            end else if (idx_q == 4'd0) begin
              if (sh_q != 8'h55) begin
                state_q  <= IDLE;
                rx_busy  <= 1'b0;
                sync_err <= 1'b1;
              end else begin
                state_q <= GAP;
              end
            end else if (idx_q == 4'd1) begin
              if (!pid_ok_d) begin
                state_q    <= IDLE;
                rx_busy    <= 1'b0;
                parity_err <= 1'b1;
              end else begin
                state_q <= GAP;
                pid_q   <= sh_q[5:0];
                sum_q   <= (ENHANCED_CS != 0) ? sh_q : 8'h00;
              end
            end else if (idx_q == IDX_CS) begin
              state_q <= DONE;
            end else begin
              state_q                      <= GAP;
              buf_q[{dsel_d, 3'b000} +: 8] <= sh_q;
              sum_q                        <= sum_add_d;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (!sdi_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end else if (cnt_q > TO_CYC) begin
            state_q     <= IDLE;
            rx_busy     <= 1'b0;
            cnt_q       <= '0;
            framing_err <= 1'b1;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          rx_busy <= 1'b0;
          cnt_q   <= '0;
          // sh_q still holds the received checksum byte.
          if (sh_q == ~sum_q) begin
            frame_valid <= 1'b1;
            rx_pid      <= pid_q;
            rx_data     <= buf_q;
          end else begin
            checksum_err <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          rx_busy <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lin_frame_rx.sv
// tb_lin_frame_rx - directed bench for lin_frame_rx with a scoreboard.
// Stimulus pushes the expected pulse (and the rx_pid/rx_data that must be
// visible with it) before driving the bytes; a negedge monitor pops and
// compares whenever any result pulse appears.
module tb_lin_frame_rx;
  localparam int CPB = 16;

  localparam logic [4:0] K_VALID = 5'b10000;
  localparam logic [4:0] K_CKS   = 5'b01000;
  localparam logic [4:0] K_PAR   = 5'b00100;
  localparam logic [4:0] K_SYNC  = 5'b00010;
  localparam logic [4:0] K_FRM   = 5'b00001;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        sdi;
  logic [5:0]  rx_pid;
  logic [63:0] rx_data;
  logic        frame_valid, rx_busy, sync_err, parity_err, framing_err, checksum_err;

  lin_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .NDATA(8),
    .ENHANCED_CS(1),
    .TIMEOUT_BITS(14)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .sdi(sdi),
    .rx_pid(rx_pid),
    .rx_data(rx_data),
    .frame_valid(frame_valid),
    .rx_busy(rx_busy),
    .sync_err(sync_err),
    .parity_err(parity_err),
    .framing_err(framing_err),
    .checksum_err(checksum_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [4:0]  kind;
    logic [5:0]  pid;
    logic [63:0] data;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [5:0]  cur_pid = '0;
  logic [63:0] cur_data = '0;
  logic [4:0]  got;

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      got = {frame_valid, checksum_err, parity_err, sync_err, framing_err};
      if (got != 5'b0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got kind=%b, required no pulse", got);
        end else begin
          e = sb.pop_front();
          if (got !== e.kind || rx_pid !== e.pid || rx_data !== e.data) begin
            bad++;
            $display("FAIL %s: got kind=%b pid=%h data=%h, required kind=%b pid=%h data=%h",
                     e.name, got, rx_pid, rx_data, e.kind, e.pid, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  // Errors carry the currently held outputs; a valid frame updates them.
  task automatic push_exp(input logic [4:0] k, input string n,
                          input logic [5:0] p, input logic [63:0] d);
    exp_t x;
    if (k == K_VALID) begin
      cur_pid  = p;
      cur_data = d;
    end
    x.kind = k;
    x.pid  = cur_pid;
    x.data = cur_data;
    x.name = n;
    sb.push_back(x);
  endtask

  task automatic bits(input logic v, input int n);
    sdi = v;
    repeat (n * CPB) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bits(1'b0, 1);
    for (int i = 0; i < 8; i++) bits(b[i], 1);
    bits(stop, 1);
  endtask

  task automatic brk();
    bits(1'b0, 13);
    bits(1'b1, 1);
  endtask

  task automatic hdr(input logic [7:0] s, input logic [7:0] p);
    brk();
    send_byte(s, 1'b1);
    send_byte(p, 1'b1);
  endtask

  task automatic data_bytes(input int n);
    logic [7:0] b;
    for (int i = 1; i <= n; i++) begin
      b = 8'(i);
      send_byte(b, 1'b1);
    end
  endtask

  // Bounded wait, then everything pushed so far must have been seen.
  task automatic drained(input string n);
    bits(1'b1, 3);
    check(n, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    sdi = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("rst_pid", 64'(rx_pid), 64'd0);
    check("rst_data", rx_data, 64'd0);
    check("rst_flags", 64'({frame_valid, rx_busy, sync_err, parity_err, framing_err, checksum_err}), 64'd0);
    rst = 1'b0;
    bits(1'b1, 2);

    // 1: good frame
    push_exp(K_VALID, "t1_valid", 6'h12, 64'h0807060504030201);
    brk();
    check("t1_busy_after_delim", 64'(rx_busy), 64'd1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h92, 1'b1);
    data_bytes(8);
    send_byte(8'h49, 1'b1);
    drained("t1_drain");
    check("t1_busy_end", 64'(rx_busy), 64'd0);

    // 2: bad checksum, outputs hold frame 1
    push_exp(K_CKS, "t2_cksum", '0, '0);
    hdr(8'h55, 8'h92);
    data_bytes(8);
    send_byte(8'h48, 1'b1);
    drained("t2_drain");

    // 3: PID with wrong parity bits
    push_exp(K_PAR, "t3_parity", '0, '0);
    hdr(8'h55, 8'h12);
    drained("t3_drain");
    check("t3_idle", 64'(rx_busy), 64'd0);

    // 4: bad sync, then a short low pulse that must be ignored
    push_exp(K_SYNC, "t4_sync", '0, '0);
    brk();
    send_byte(8'h54, 1'b1);
    drained("t4_drain");
    bits(1'b0, 10);
    check("t4_short_busy_low", 64'(rx_busy), 64'd0);
    bits(1'b1, 3);
    check("t4_short_busy_after", 64'(rx_busy), 64'd0);

    // 5a: stop bit of data byte 3 low
    push_exp(K_FRM, "t5_stop", '0, '0);
    hdr(8'h55, 8'h92);
    data_bytes(2);
    send_byte(8'h03, 1'b0);
    bits(1'b1, 2);
    drained("t5a_drain");

    // 5b: 20 bit-time gap after data byte 4
    push_exp(K_FRM, "t5_timeout", '0, '0);
    hdr(8'h55, 8'h92);
    data_bytes(4);
    bits(1'b1, 20);
    drained("t5b_drain");

    // 6: reset in the middle of data byte 5, then a clean frame
    hdr(8'h55, 8'h92);
    data_bytes(4);
    bits(1'b0, 1);
    bits(1'b1, 2);
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("t6_rst_pid", 64'(rx_pid), 64'd0);
    check("t6_rst_data", rx_data, 64'd0);
    check("t6_rst_flags", 64'({frame_valid, rx_busy, sync_err, parity_err, framing_err, checksum_err}), 64'd0);
    cur_pid  = '0;
    cur_data = '0;
    rst = 1'b0;
    sdi = 1'b1;
    bits(1'b1, 2);
    check("t6_no_pending", 64'(sb.size()), 64'd0);
    // 3C+10+...+80 with end-around carry = 7E, checksum = 81
    push_exp(K_VALID, "t6_valid", 6'h3C, 64'h8070605040302010);
    hdr(8'h55, 8'h3C);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 16), 1'b1);
    send_byte(8'h81, 1'b1);
    drained("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
